msi_bus_arbiter: RTL and testbench

Snooping coherence bus controller for the two-core system, sitting directly downstream of each core's `cache_controller`. It does four things:
- Collects read-miss, write-miss, invalidate and unified-memory requests from both cores.
- Serialises them with a round-robin arbiter.
- Runs the snoop of the other core's Dcache.
- Returns `grant`, `cpu_datasel`, forwarded data and invalidations.

It is the only source of `grant`, `cpu_search`, `BOCI`, `cpu_datasel`, `other_proc_data` and `invalidate_from_other_cpu` for both cache controllers.

---
 rtl/msi_bus_arbiter_pkg.sv | 38 +++
 rtl/msi_bus_arbiter_rr_arbiter2.sv | 33 +++
 rtl/msi_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_msi_bus_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/msi_bus_arbiter_pkg.sv
// Shared types and constants for the two-core MSI snooping bus controller.
package msi_bus_arbiter_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    // Fill source seen by a cache controller on a miss.
    localparam logic [1:0] SOURCE_DMEM       = 2'b00;
    localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_RD   = 3'd1,
        BUS_WR   = 3'd2,
        BUS_INV  = 3'd3,
        BUS_MEM  = 3'd4
    } bus_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_RESP  = 2'd2,
        ST_MEM   = 2'd3
    } bus_state_t;

    // Collapse one core's request lines into a single type, INV first, MEM last.
    function automatic bus_req_t classify_req(input logic inv, input logic wr,
                                              input logic rd, input logic mem);
        bus_req_t t;
        if (inv)      t = BUS_INV;
        else if (wr)  t = BUS_WR;
        else if (rd)  t = BUS_RD;
        else if (mem) t = BUS_MEM;
        else          t = BUS_NONE;
        return t;
    endfunction

endpackage

// File: rtl/msi_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot winner, pointer advances to the
// core that was not just served whenever a transaction completes.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    // Pick the sole requester, or the pointed-at core when both request.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Hand priority to the other core after each completed transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 1'b0;
        else if (adv_i)
            ptr_q <= ~last_i;
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snooping coherence bus controller for two cores: arbitrates misses,
// upgrades and unified-memory accesses, snoops the other core's Dcache and
// returns grant, fill source, forwarded data and invalidations.
module msi_bus_arbiter
    import msi_bus_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             read_miss,
    input  logic [1:0]             write_miss,
    input  logic [1:0]             invalidate,
    input  logic [1:0]             mem_req,
    input  logic [1:0][ADDR_W-1:0] bico,
    input  logic [1:0]             cpu_search_found,
    input  logic [1:0][DATA_W-1:0] send_other_proc_data,
    input  logic                   u_rdy,
    output logic [1:0]             grant,
    output logic [1:0]             cpu_search,
    output logic [1:0][ADDR_W-1:0] boci,
    output logic [1:0][1:0]        cpu_datasel,
    output logic [1:0][DATA_W-1:0] other_proc_data,
    output logic [1:0]             invalidate_from_other_cpu
);

    bus_state_t        state_q;
    bus_req_t          type_q;
    logic              r_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              found_q;
    logic [DATA_W-1:0] fwd_q;

    logic [1:0] core_req;
    logic [1:0] win_oh;
    logic       any_req;
    logic       win_idx;
    bus_req_t   win_type;
    logic       o_idx;
    logic       mem_done;
    logic       adv;

    assign core_req = read_miss | write_miss | invalidate | mem_req;
    assign any_req  = |win_oh;
    assign win_idx  = win_oh[1];
    assign o_idx    = ~r_q;
    assign win_type = classify_req(invalidate[win_idx], write_miss[win_idx],
                                   read_miss[win_idx], mem_req[win_idx]);
    assign mem_done = (state_q == ST_MEM) && mem_req[r_q] && u_rdy;
    // A coherence transaction completes when RESP retires; a memory one on its u_rdy beat.
    assign adv      = (state_q == ST_RESP) || mem_done;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (core_req),
        .adv_i  (adv),
        .last_i (r_q),
        .gnt_o  (win_oh)
    );

    // Transaction sequencer: accept in IDLE, one-cycle SNOOP and RESP, MEM until u_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= 1'b0;
            type_q  <= BUS_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        r_q     <= win_idx;
                        type_q  <= win_type;
                        state_q <= (win_type == BUS_MEM) ? ST_MEM : ST_SNOOP;
                    end
                end
                ST_SNOOP: state_q <= ST_RESP;
                ST_RESP:  state_q <= ST_IDLE;
                ST_MEM: begin
                    // Done on the u_rdy beat, or abandoned if the core withdraws.
                    if (!mem_req[r_q] || u_rdy)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Request address and snoop result; only consumed in states that follow their capture.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE)
            req_addr_q <= bico[win_idx];
        if (state_q == ST_SNOOP) begin
            found_q <= cpu_search_found[o_idx];
            fwd_q   <= send_other_proc_data[o_idx];
        end
    end

    // Outputs decode only registered state, so requests never reach grant combinationally.
    always_comb begin
        grant                     = 2'b00;
        cpu_search                = 2'b00;
        boci                      = '0;
        cpu_datasel               = '0;
        other_proc_data           = '0;
        invalidate_from_other_cpu = 2'b00;
        case (state_q)
            ST_SNOOP: begin
                cpu_search[o_idx] = 1'b1;
                boci[o_idx]       = req_addr_q;
            end
            ST_RESP: begin
                grant[r_q] = 1'b1;
                if (type_q != BUS_INV) begin
                    cpu_datasel[r_q]     = found_q ? SOURCE_OTHER_PROC : SOURCE_DMEM;
                    other_proc_data[r_q] = fwd_q;
                end else begin
                    cpu_datasel[r_q] = SOURCE_DMEM;
                end
                if ((type_q == BUS_WR) || (type_q == BUS_INV)) begin
                    invalidate_from_other_cpu[o_idx] = 1'b1;
                    boci[o_idx]                      = req_addr_q;
                end
            end
            ST_MEM: grant[r_q] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: directed transactions push expected
// bus activity (with the cycle it must appear in); a negedge monitor pops and
// compares whenever the DUT drives grant, cpu_search or an invalidate.
module tb_msi_bus_arbiter;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_INV = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        read_miss, write_miss, invalidate, mem_req;
    logic [1:0][12:0]  bico;
    logic [1:0]        cpu_search_found;
    logic [1:0][15:0]  send_other_proc_data;
    logic              u_rdy;
    logic [1:0]        grant, cpu_search;
    logic [1:0][12:0]  boci;
    logic [1:0][1:0]   cpu_datasel;
    logic [1:0][15:0]  other_proc_data;
    logic [1:0]        invalidate_from_other_cpu;

    typedef struct {
        int          cyc;
        logic [67:0] v;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          k;
    int          m;
    logic [67:0] mon_act;
    exp_t        mon_e;

    msi_bus_arbiter dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .mem_req                   (mem_req),
        .bico                      (bico),
        .cpu_search_found          (cpu_search_found),
        .send_other_proc_data      (send_other_proc_data),
        .u_rdy                     (u_rdy),
        .grant                     (grant),
        .cpu_search                (cpu_search),
        .boci                      (boci),
        .cpu_datasel               (cpu_datasel),
        .other_proc_data           (other_proc_data),
        .invalidate_from_other_cpu (invalidate_from_other_cpu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [67:0] pack(input logic [1:0] g, input logic [1:0] s,
                                         input logic [1:0] iv, input logic [1:0][12:0] b,
                                         input logic [1:0][1:0] d, input logic [1:0][15:0] p);
        return {g, s, iv, b, d, p};
    endfunction

    function automatic logic [67:0] outs();
        return pack(grant, cpu_search, invalidate_from_other_cpu, boci, cpu_datasel, other_proc_data);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [67:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.v = v; e.name = nm;
        q.push_back(e);
    endtask

    // Expected snoop and response of a coherence transaction accepted at edge kk+1.
    task automatic coh_exp(input int kk, input int r, input int kind, input logic [12:0] addr,
                           input logic found, input logic [15:0] fwd, input string nm);
        logic [1:0]       g, s, iv;
        logic [1:0][12:0] b;
        logic [1:0][1:0]  d;
        logic [1:0][15:0] p;
        g = '0; s = '0; iv = '0; b = '0; d = '0; p = '0;
        s[1-r] = 1'b1;
        b[1-r] = addr;
        push(kk + 1, pack(g, s, iv, b, d, p), {nm, "_snoop"});
        s = '0;
        g[r] = 1'b1;
        if (kind != K_INV) begin
            d[r] = found ? 2'b01 : 2'b00;
            p[r] = fwd;
        end
        if (kind == K_RD) b = '0;
        else              iv[1-r] = 1'b1;
        push(kk + 2, pack(g, s, iv, b, d, p), {nm, "_resp"});
    endtask

    task automatic check_now(input string nm, input logic [67:0] e);
        logic [67:0] a;
        a = outs();
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor: every cycle with bus activity must match the next scoreboard entry.
    always @(negedge clk) begin
        mon_act = outs();
        if (|mon_act[67:62]) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_activity: got %h at cyc %0d, expected none", mon_act, cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_act !== mon_e.v || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d",
                             mon_e.name, mon_act, cyc, mon_e.v, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        read_miss = '0; write_miss = '0; invalidate = '0; mem_req = '0;
        bico = '0; cpu_search_found = '0; send_other_proc_data = '0; u_rdy = 1'b0;
        tick(2);
        check_now("reset_outputs", 68'h0);
        rst_n = 1'b1;
        tick(1);
        check_now("idle_after_reset", 68'h0);

        // Core0 read miss, snoop miss.
        k = cyc;
        bico[0] = 13'h0104; send_other_proc_data[1] = 16'h1111; cpu_search_found = 2'b00;
        read_miss = 2'b01;
        coh_exp(k, 0, K_RD, 13'h0104, 1'b0, 16'h1111, "c0_rd_miss");
        tick(2); read_miss = 2'b00; tick(1);

        // Core0 upgrade invalidate.
        k = cyc;
        bico[0] = 13'h0A08; send_other_proc_data = '0;
        invalidate = 2'b01;
        coh_exp(k, 0, K_INV, 13'h0A08, 1'b0, 16'h0000, "c0_inv");
        tick(2); invalidate = 2'b00; tick(1);

        // Core1 read miss, core0 snoop hit supplies the word.
        k = cyc;
        bico[1] = 13'h0155; send_other_proc_data[0] = 16'hBEEF; cpu_search_found = 2'b01;
        read_miss = 2'b10;
        coh_exp(k, 1, K_RD, 13'h0155, 1'b1, 16'hBEEF, "c1_rd_hit");
        tick(2); read_miss = 2'b00; cpu_search_found = 2'b00; tick(1);

        // Same-address WR(core0) vs RD(core1) with rr=0: core0 first, core1 back-to-back.
        k = cyc;
        bico[0] = 13'h0222; bico[1] = 13'h0222;
        send_other_proc_data[0] = 16'h3333; send_other_proc_data[1] = 16'h2222;
        write_miss = 2'b01; read_miss = 2'b10;
        coh_exp(k, 0, K_WR, 13'h0222, 1'b0, 16'h2222, "conf_c0_wr");
        coh_exp(k + 3, 1, K_RD, 13'h0222, 1'b0, 16'h3333, "conf_c1_rd");
        tick(2); write_miss = 2'b00; tick(3); read_miss = 2'b00; tick(1);

        // Both read at once: rr must be back at 0, so core0 wins again.
        k = cyc;
        bico[0] = 13'h0444; bico[1] = 13'h0555;
        send_other_proc_data[0] = 16'h0B0B; send_other_proc_data[1] = 16'h0A0A;
        read_miss = 2'b11;
        coh_exp(k, 0, K_RD, 13'h0444, 1'b0, 16'h0A0A, "both_c0_rd");
        coh_exp(k + 3, 1, K_RD, 13'h0555, 1'b0, 16'h0B0B, "both_c1_rd");
        tick(2); read_miss = 2'b10; tick(3); read_miss = 2'b00; tick(1);

        // Core1 memory access: u_rdy low 4 cycles then high, grant held 5 cycles.
        k = cyc;
        bico[1] = 13'h0666; mem_req = 2'b10; u_rdy = 1'b0;
        for (int i = 1; i <= 5; i++)
            push(k + i, pack(2'b10, 2'b00, 2'b00, '0, '0, '0), "c1_mem_grant");
        tick(1);
        bico[0] = 13'h0333; send_other_proc_data[1] = 16'h0C0C; read_miss = 2'b01;
        tick(4); u_rdy = 1'b1;
        tick(1); u_rdy = 1'b0; mem_req = 2'b00;
        coh_exp(k + 6, 0, K_RD, 13'h0333, 1'b0, 16'h0C0C, "pending_c0_rd");
        tick(2); read_miss = 2'b00; tick(1);

        // Reset during RESP of core1 WR (rr=1): no grant/invalidate, rr back to 0.
        k = cyc;
        bico[0] = 13'h0777; bico[1] = 13'h0888; send_other_proc_data = '0;
        read_miss = 2'b01; write_miss = 2'b10;
        push(k + 1, pack(2'b00, 2'b01, 2'b00, {13'h0000, 13'h0888}, '0, '0), "abort_c1_snoop");
        tick(2);
        rst_n = 1'b0;
        #1;
        check_now("reset_in_resp", 68'h0);
        tick(2);
        rst_n = 1'b1;
        m = cyc;
        coh_exp(m, 0, K_RD, 13'h0777, 1'b0, 16'h0000, "rearb_c0_rd");
        coh_exp(m + 3, 1, K_WR, 13'h0888, 1'b0, 16'h0000, "rearb_c1_wr");
        tick(2); read_miss = 2'b00; tick(3); write_miss = 2'b00; tick(3);

        while (q.size() > 0) begin
            mon_e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no activity, expected %h at cyc %0d", mon_e.name, mon_e.v, mon_e.cyc);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
